// File: rtl/tx_serializer.sv
// Serial transmit stage behind the 8b/10b encoder: owns running disparity, shifts symbols
// MSB-first, sends a comma preamble after reset and fills idle symbol slots with K28.5.
module tx_serializer #(
    parameter int CLK_PER_BIT = 4,
    parameter int SYNC_COMMAS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [9:0] word_in,
    input  logic       rd_next_in,
    input  logic       enc_err_in,
    input  logic       word_valid,
    output logic       word_ready,
    output logic       rd_cur,
    output logic       ser_out,
    output logic       sync_done,
    output logic       err_sticky,
    input  logic       err_clr,
    output logic       state_dbg
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] CNT_MAX   = 4'(CLK_PER_BIT - 1);
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_COMMAS - 1);
    localparam logic [9:0] COMMA_RDN = 10'b0011111010;
    localparam logic [9:0] COMMA_RDP = 10'b1100000101;

    state_t     state, state_nxt;
    logic [3:0] clk_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] sync_cnt;
    logic [9:0] shreg;
    logic [9:0] comma;
    logic       boundary;
    logic       go_run;
    logic       accept;

    assign boundary  = (clk_cnt == CNT_MAX) && (bit_cnt == 4'd9);
    assign comma     = rd_cur ? COMMA_RDP : COMMA_RDN;
    assign ser_out   = shreg[9];
    assign state_dbg = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:    if (boundary && (sync_cnt == SYNC_LAST)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = SYNC;
        endcase
    end

    // Handshake: word_ready is high only on a RUN symbol boundary with tx_en set and never
    // depends on word_valid; a word transfers on a cycle where both are high, otherwise the
    // upstream stage holds it.
    always_comb begin
        word_ready = 1'b0;
        accept     = 1'b0;
        go_run     = 1'b0;
        case (state)
            SYNC: go_run = boundary && (sync_cnt == SYNC_LAST);
            RUN: begin
                word_ready = boundary && tx_en;
                accept     = boundary && tx_en && word_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= CNT_MAX;
            bit_cnt <= 4'd9;
            shreg   <= 10'd0;
        end else if (boundary) begin
            shreg   <= accept ? word_in : comma;
            clk_cnt <= 4'd0;
            bit_cnt <= 4'd0;
        end else if (clk_cnt == CNT_MAX) begin
            shreg   <= {shreg[8:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
            clk_cnt <= 4'd0;
        end else begin
            clk_cnt <= clk_cnt + 4'd1;
        end
    end

    // Disparity only moves at boundaries so the encoder sees a stable RDin for a whole symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cur    <= 1'b0;
            sync_cnt  <= 8'd0;
            sync_done <= 1'b0;
        end else begin
            if (boundary) begin
                rd_cur <= accept ? rd_next_in : ~rd_cur;
                if (state == SYNC) sync_cnt <= sync_cnt + 8'd1;
            end
            if (go_run) sync_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end else if (accept && enc_err_in) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: directed vector table, reset/preamble sequences and a random run,
// all checked every cycle against a symbol-level reference model.
module tb_tx_serializer;

    localparam int CPB   = 4;
    localparam int SYNCN = 4;
    localparam int SYM   = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_en = 1'b0;
    logic [9:0] word_in = 10'd0;
    logic       rd_next_in = 1'b0;
    logic       enc_err_in = 1'b0;
    logic       word_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       word_ready, rd_cur, ser_out, sync_done, err_sticky, state_dbg;

    tx_serializer #(.CLK_PER_BIT(CPB), .SYNC_COMMAS(SYNCN)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .word_in(word_in),
        .rd_next_in(rd_next_in), .enc_err_in(enc_err_in), .word_valid(word_valid),
        .word_ready(word_ready), .rd_cur(rd_cur), .ser_out(ser_out),
        .sync_done(sync_done), .err_sticky(err_sticky), .err_clr(err_clr),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         m_t;
    int         m_phase;
    int         m_syncs;
    logic       m_rd, m_run, m_err;
    logic [9:0] exp_q[$];
    logic [9:0] cap;

    typedef struct {
        logic       tx_en;
        logic       valid;
        logic [9:0] word;
        logic       rd_next;
        logic       err;
        logic       clr;
        logic [9:0] exp_sym;
        logic       exp_rd;
        logic       exp_err;
    } vec_t;

    function automatic logic [9:0] comma(input logic rd);
        return rd ? 10'b1100000101 : 10'b0011111010;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_phase = 0; m_syncs = 0;
        m_rd = 1'b0; m_run = 1'b0; m_err = 1'b0;
        exp_q.delete();
        cap = 10'd0;
    endtask

    // One clock edge of the reference: a new symbol starts every SYM edges after release.
    task automatic model_edge();
        logic [9:0] sym;
        logic       set_err;
        set_err = 1'b0;
        m_phase = m_t % SYM;
        if (m_phase == 0) begin
            if (!m_run) begin
                sym = comma(m_rd);
                m_rd = ~m_rd;
                m_syncs++;
                if (m_syncs == SYNCN) m_run = 1'b1;
            end else if (tx_en && word_valid) begin
                sym = word_in;
                m_rd = rd_next_in;
                set_err = enc_err_in;
            end else begin
                sym = comma(m_rd);
                m_rd = ~m_rd;
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_q.push_back(sym);
        end
        m_err = err_clr ? 1'b0 : (m_err | set_err);
        m_t++;
    endtask

    task automatic step();
        logic [9:0] sym_t;
        logic       exp_ser;
        #1;
        check_bit("word_ready", word_ready, m_run && (m_t % SYM == 0) && tx_en);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        sym_t = (exp_q.size() > 0) ? exp_q[0] : 10'd0;
        exp_ser = sym_t[9 - m_phase / CPB];
        check_bit("ser_out", ser_out, exp_ser);
        check_bit("rd_cur", rd_cur, m_rd);
        check_bit("sync_done", sync_done, m_run);
        check_bit("state_dbg", state_dbg, m_run);
        check_bit("err_sticky", err_sticky, m_err);
        if (m_phase % CPB == CPB - 1) cap = {cap[8:0], ser_out};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_bit("rst_ser_out", ser_out, 1'b0);
        check_bit("rst_rd_cur", rd_cur, 1'b0);
        check_bit("rst_sync_done", sync_done, 1'b0);
        check_bit("rst_word_ready", word_ready, 1'b0);
        check_bit("rst_err_sticky", err_sticky, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_boundary();
        word_valid = 1'b0;
        while (m_t % SYM != 0) step();
    endtask

    vec_t vec[10];

    initial begin
        vec[0] = '{1'b1, 1'b1, 10'b1001110100, 1'b0, 1'b0, 1'b0, 10'b1001110100, 1'b0, 1'b0};
        vec[1] = '{1'b1, 1'b1, 10'b0110001011, 1'b1, 1'b0, 1'b0, 10'b0110001011, 1'b1, 1'b0};
        vec[2] = '{1'b1, 1'b1, 10'b1010101010, 1'b0, 1'b0, 1'b0, 10'b1010101010, 1'b0, 1'b0};
        vec[3] = '{1'b1, 1'b1, 10'b0101010101, 1'b1, 1'b0, 1'b0, 10'b0101010101, 1'b1, 1'b0};
        vec[4] = '{1'b1, 1'b0, 10'b0000000000, 1'b0, 1'b0, 1'b0, 10'b1100000101, 1'b0, 1'b0};
        vec[5] = '{1'b1, 1'b1, 10'b1110000110, 1'b1, 1'b1, 1'b0, 10'b1110000110, 1'b1, 1'b1};
        vec[6] = '{1'b1, 1'b1, 10'b0001111001, 1'b0, 1'b0, 1'b0, 10'b0001111001, 1'b0, 1'b1};
        vec[7] = '{1'b1, 1'b0, 10'b0000000000, 1'b0, 1'b0, 1'b0, 10'b0011111010, 1'b1, 1'b1};
        vec[8] = '{1'b1, 1'b1, 10'b1100011010, 1'b0, 1'b1, 1'b1, 10'b1100011010, 1'b0, 1'b0};
        vec[9] = '{1'b0, 1'b1, 10'b1111100000, 1'b1, 1'b0, 1'b0, 10'b0011111010, 1'b1, 1'b0};

        model_reset();
        #2;
        do_reset();

        // Preamble then idle commas with tx_en low.
        tx_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            repeat (SYM) step();
            check_word("idle_sym", cap, (k % 2 == 1) ? 10'b1100000101 : 10'b0011111010);
            check_bit("idle_rd", rd_cur, (k % 2 == 0));
            check_bit("idle_sync_done", sync_done, (k >= 3));
        end

        // Directed word table, back-to-back from a boundary at RD-.
        run_to_boundary();
        for (int i = 0; i < 10; i++) begin
            tx_en      = vec[i].tx_en;
            word_valid = vec[i].valid;
            word_in    = vec[i].word;
            rd_next_in = vec[i].rd_next;
            enc_err_in = vec[i].err;
            err_clr    = vec[i].clr;
            step();
            word_valid = 1'b0;
            enc_err_in = 1'b0;
            err_clr    = 1'b0;
            repeat (SYM - 1) step();
            check_word("vec_sym", cap, vec[i].exp_sym);
            check_bit("vec_rd", rd_cur, vec[i].exp_rd);
            check_bit("vec_err", err_sticky, vec[i].exp_err);
        end

        // Reset in the middle of a data symbol, then the preamble must repeat.
        tx_en = 1'b1;
        run_to_boundary();
        word_valid = 1'b1;
        word_in    = 10'b1011001100;
        rd_next_in = 1'b1;
        step();
        word_valid = 1'b0;
        repeat (15) step();
        #2;
        do_reset();
        word_valid = 1'b1;
        for (int k = 0; k < 5 * SYM; k++) begin
            word_in    = 10'($urandom);
            rd_next_in = 1'($urandom_range(0, 1));
            step();
            if (k == SYM - 1) check_word("restart_comma0", cap, 10'b0011111010);
            if (k == 2 * SYM - 1) check_word("restart_comma1", cap, 10'b1100000101);
        end

        // Random traffic, inputs changing every cycle including mid-symbol.
        for (int k = 0; k < 1500; k++) begin
            tx_en      = ($urandom_range(0, 9) != 0);
            word_valid = ($urandom_range(0, 3) != 0);
            word_in    = 10'($urandom);
            rd_next_in = 1'($urandom_range(0, 1));
            enc_err_in = ($urandom_range(0, 15) == 0);
            err_clr    = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
